dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be ADDRESS_WIDTH (default 32), DATA_WIDTH (default 32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cpu_req / cpu_we / cpu_byte  input  1 each  CPU port access request, write enable, byte operation.
REQ-005 cpu_addr  input  ADDRESS_WIDTH  CPU access address.
REQ-006 cpu_wdata  input  DATA_WIDTH  CPU write data.
REQ-007 cpu_gnt  output  1  CPU access accepted this cycle.
REQ-008 cpu_rvalid  output  1  CPU read data valid.
REQ-009 cpu_rdata  output  DATA_WIDTH  CPU read data.
REQ-010 ldr_req / ldr_we / ldr_byte / ldr_lock  input  1 each  loader port request, write enable, byte op, burst lock.
REQ-011 ldr_addr / ldr_wdata  input  ADDRESS_WIDTH / DATA_WIDTH  loader address and write data.
REQ-012 ldr_gnt / ldr_rvalid  output  1 each  loader grant and read-valid.
REQ-013 ldr_rdata  output  DATA_WIDTH  loader read data.
REQ-014 mem_we / mem_byteop  output  1 each  to data memory write enable and byte operation.
REQ-015 mem_addr / mem_wdata  output  ADDRESS_WIDTH / DATA_WIDTH  to data memory address and write data.
REQ-016 mem_rdata  input  DATA_WIDTH  combinational read data from data memory.

Function
REQ-017 At most one of cpu_gnt, ldr_gnt SHALL be high in any cycle; grant is combinational from current requests and registered state.
REQ-018 Granted port's we/byte/addr/wdata SHALL drive mem_* in the grant cycle; with no grant, mem_we=0, mem_byteop=0, mem_addr=0, mem_wdata=0.
REQ-019 FSM states SHALL be IDLE, RR (normal round-robin) and LOCK; IDLE->RR on any request, RR->IDLE when no request, RR->LOCK when loader granted with ldr_lock=1, LOCK->RR (or IDLE if no request) in the first cycle ldr_lock=0 or ldr_req=0.
REQ-020 In IDLE/RR with one requester, that requester SHALL be granted; with both, the port not granted last (last_gnt register, reset value CPU) SHALL be granted.
REQ-021 last_gnt SHALL update only on cycles with a grant.
REQ-022 In LOCK, loader SHALL be granted every cycle it requests and cpu_gnt SHALL be 0 regardless of cpu_req.
REQ-023 Read grant (we=0): mem_rdata SHALL be registered into the granted port's rdata, with its rvalid high exactly one cycle after the grant (latency 1), for one cycle.
REQ-024 Write grant: the write SHALL commit at the grant-cycle edge; no rvalid SHALL be generated.
REQ-025 rdata of a port SHALL hold its last value when rvalid is low.
REQ-026 Back-to-back reads on alternating ports SHALL give one rvalid per cycle, each to the correct port, no bubbles.
REQ-027 A requester SHALL hold req and its signals stable until granted; dropping req without grant is legal and causes no access.
REQ-028 Byte/word addressing, alignment and endianness SHALL be passed through unchanged; the arbiter performs no address arithmetic.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, last_gnt=CPU, cpu_gnt=ldr_gnt=0, cpu_rvalid=ldr_rvalid=0, cpu_rdata=ldr_rdata=0, mem_we=0.
REQ-030 Reset asserted with a read in flight SHALL discard it: no rvalid after deassertion.
REQ-031 First edge after rst_n deassertion SHALL treat the arbiter as IDLE with no pending access.

Verification
REQ-032 CPU only: word write addr 0x100 data 0xDEADBEEF, then read 0x100 -> cpu_gnt both cycles, cpu_rvalid one cycle later, cpu_rdata=0xDEADBEEF, ldr_rvalid stays 0.
REQ-033 Both request reads every cycle for 4 cycles after reset -> grants CPU? no: last_gnt=CPU so LDR, CPU, LDR, CPU; rvalids follow one cycle later on matching port.
REQ-034 Loader lock: ldr_req=ldr_lock=1 for 3 writes with cpu_req=1 throughout -> ldr_gnt 3 cycles, cpu_gnt 0; after lock drops, cpu_gnt next cycle.
REQ-035 Byte write: ldr_byte=1, ldr_we=1, addr 0x203, data 0x5A -> mem_byteop=1, mem_addr=0x203, mem_wdata=0x5A in grant cycle.
REQ-036 Reset mid-read: grant CPU read, assert rst_n=0 before the next edge -> cpu_rvalid never asserts; all outputs 0 while reset held.
REQ-037 Idle: no requests for 10 cycles -> all grants/rvalids 0, mem_we=0, state IDLE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (CPU, loader) arbiter in front of a single data memory.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req/we/byte/addr/wdata CPU request port; cpu_gnt, cpu_rvalid, cpu_rdata back
//   ldr_req/we/byte/lock/addr/wdata
//                              loader request port, ldr_lock holds a burst;
//                              ldr_gnt, ldr_rvalid, ldr_rdata back
//   mem_we/byteop/addr/wdata   to data memory, driven by the granted port
//   mem_rdata                  combinational read data from data memory
//
// Grant is combinational from the current requests and registered state.
// Read data is captured at the grant edge and presented with rvalid one
// cycle later. Addresses and data pass through untouched.
module dmem_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic                     cpu_byte,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic                     cpu_gnt,
  output logic                     cpu_rvalid,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  input  logic                     ldr_req,
  input  logic                     ldr_we,
  input  logic                     ldr_byte,
  input  logic                     ldr_lock,
  input  logic [ADDRESS_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0]    ldr_wdata,
  output logic                     ldr_gnt,
  output logic                     ldr_rvalid,
  output logic [DATA_WIDTH-1:0]    ldr_rdata,
  output logic                     mem_we,
  output logic                     mem_byteop,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RR, S_LOCK} state_e;

  state_e                  state_q;
  logic                    last_ldr_q;   // 1: loader was granted last, 0: CPU
  logic                    cpu_rvalid_q, ldr_rvalid_q;
  logic [DATA_WIDTH-1:0]   cpu_rdata_q,  ldr_rdata_q;

  // Grant decode. Gated by rst_n so grants (and hence mem_*) drop the
  // moment reset asserts, not at the next edge.
  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (rst_n) begin
      if (state_q == S_LOCK) begin
        ldr_gnt = ldr_req;
      end else if (cpu_req && ldr_req) begin
        cpu_gnt = last_ldr_q;
        ldr_gnt = !last_ldr_q;
      end else begin
        cpu_gnt = cpu_req;
        ldr_gnt = ldr_req;
      end
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_byteop = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (cpu_gnt) begin
      mem_we     = cpu_we;
      mem_byteop = cpu_byte;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_we     = ldr_we;
      mem_byteop = ldr_byte;
      mem_addr   = ldr_addr;
      mem_wdata  = ldr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_ldr_q   <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      case (state_q)
        // A locked loader grant taken straight from IDLE still has to hold
        // the bus next cycle, so IDLE may enter LOCK directly.
        S_IDLE, S_RR: begin
          if (ldr_gnt && ldr_lock)     state_q <= S_LOCK;
          else if (cpu_req || ldr_req) state_q <= S_RR;
          else                         state_q <= S_IDLE;
        end
        // The cycle the lock drops is still a LOCK cycle; the CPU competes
        // again from the following cycle.
        S_LOCK: begin
          if (ldr_req && ldr_lock)     state_q <= S_LOCK;
          else if (cpu_req || ldr_req) state_q <= S_RR;
          else                         state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (cpu_gnt || ldr_gnt) last_ldr_q <= ldr_gnt;

      cpu_rvalid_q <= cpu_gnt && !cpu_we;
      ldr_rvalid_q <= ldr_gnt && !ldr_we;
      if (cpu_gnt && !cpu_we) cpu_rdata_q <= mem_rdata;
      if (ldr_gnt && !ldr_we) ldr_rdata_q <= mem_rdata;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign ldr_rvalid = ldr_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and a word memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, cpu_byte = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        ldr_req = 0, ldr_we = 0, ldr_byte = 0, ldr_lock = 0;
  logic [31:0] ldr_addr = 0, ldr_wdata = 0;
  logic        ldr_gnt, ldr_rvalid;
  logic [31:0] ldr_rdata;
  logic        mem_we, mem_byteop;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0, n_fail = 0;

  dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_byte(ldr_byte), .ldr_lock(ldr_lock),
    .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_we(mem_we), .mem_byteop(mem_byteop), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: word array, combinational read, write at the edge.
  logic [31:0] e_mem [256];
  assign mem_rdata = e_mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) e_mem[mem_addr[9:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [256];
  logic        m_last_ldr = 0, m_lock = 0;
  logic        m_crv = 0, m_lrv = 0;
  logic [31:0] m_crd = 0, m_lrd = 0;
  logic        c_took = 0, l_took = 0;   // grants seen, used by the driver

  initial begin
    for (int i = 0; i < 256; i++) begin
      e_mem[i] = 32'h0;
      m_mem[i] = 32'h0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_last_ldr = 0; m_lock = 0; m_crv = 0; m_lrv = 0; m_crd = 0; m_lrd = 0;
        c_took = 0; l_took = 0;
        chk("rst cpu_gnt", cpu_gnt, 0);
        chk("rst ldr_gnt", ldr_gnt, 0);
        chk("rst cpu_rvalid", cpu_rvalid, 0);
        chk("rst ldr_rvalid", ldr_rvalid, 0);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst ldr_rdata", ldr_rdata, 0);
        chk("rst mem_we", mem_we, 0);
      end else begin
        logic eg_c, eg_l, e_we, e_bo;
        logic [31:0] e_ad, e_wd;
        chk("cpu_rvalid", cpu_rvalid, m_crv);
        chk("cpu_rdata", cpu_rdata, m_crd);
        chk("ldr_rvalid", ldr_rvalid, m_lrv);
        chk("ldr_rdata", ldr_rdata, m_lrd);
        // Lock blocks the CPU outright; otherwise contention goes to the
        // port that was not served last.
        eg_c = !m_lock && cpu_req && (!ldr_req || m_last_ldr);
        eg_l = ldr_req && (m_lock || !cpu_req || !m_last_ldr);
        chk("cpu_gnt", cpu_gnt, eg_c);
        chk("ldr_gnt", ldr_gnt, eg_l);
        e_we = 0; e_bo = 0; e_ad = 0; e_wd = 0;
        if (eg_c) begin e_we = cpu_we; e_bo = cpu_byte; e_ad = cpu_addr; e_wd = cpu_wdata; end
        else if (eg_l) begin e_we = ldr_we; e_bo = ldr_byte; e_ad = ldr_addr; e_wd = ldr_wdata; end
        chk("mem_we", mem_we, e_we);
        chk("mem_byteop", mem_byteop, e_bo);
        chk("mem_addr", mem_addr, e_ad);
        chk("mem_wdata", mem_wdata, e_wd);
        m_crv = eg_c && !cpu_we;
        m_lrv = eg_l && !ldr_we;
        if (m_crv) m_crd = m_mem[cpu_addr[9:2]];
        if (m_lrv) m_lrd = m_mem[ldr_addr[9:2]];
        if (e_we) m_mem[e_ad[9:2]] = e_wd;
        if (eg_c || eg_l) m_last_ldr = eg_l;
        m_lock = eg_l && ldr_lock;
        c_took = cpu_gnt; l_took = ldr_gnt;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_cpu(input logic r, w, b, input logic [31:0] a, d);
    cpu_req = r; cpu_we = w; cpu_byte = b; cpu_addr = a; cpu_wdata = d;
  endtask
  task automatic set_ldr(input logic r, w, b, l, input logic [31:0] a, d);
    ldr_req = r; ldr_we = w; ldr_byte = b; ldr_lock = l; ldr_addr = a; ldr_wdata = d;
  endtask
  task automatic drv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); #1; endtask

  initial begin
    int lock_left = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // CPU word write then read-back.
    set_cpu(1, 1, 0, 32'h100, 32'hDEADBEEF);
    smp();
    chk("w cpu_gnt", cpu_gnt, 1); chk("w ldr_gnt", ldr_gnt, 0);
    chk("w mem_we", mem_we, 1); chk("w mem_addr", mem_addr, 32'h100);
    chk("w mem_wdata", mem_wdata, 32'hDEADBEEF);
    drv(); set_cpu(1, 0, 0, 32'h100, 0);
    smp(); chk("r cpu_gnt", cpu_gnt, 1); chk("r mem_we", mem_we, 0);
    drv(); set_cpu(0, 0, 0, 0, 0);
    smp(); chk("r cpu_rvalid", cpu_rvalid, 1); chk("r cpu_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("r ldr_rvalid", ldr_rvalid, 0);
    drv(); smp(); chk("r rvalid drop", cpu_rvalid, 0); chk("r rdata hold", cpu_rdata, 32'hDEADBEEF);

    // Both read every cycle: loader first since CPU was served last.
    for (int k = 0; k < 4; k++) begin
      drv(); set_cpu(1, 0, 0, 32'h100, 0); set_ldr(1, 0, 0, 0, 32'h100, 0);
      smp();
      chk("alt ldr_gnt", ldr_gnt, (k % 2) == 0);
      chk("alt cpu_gnt", cpu_gnt, (k % 2) == 1);
      chk("alt ldr_rvalid", ldr_rvalid, (k % 2) == 1);
      chk("alt cpu_rvalid", cpu_rvalid, k != 0 && (k % 2) == 0);
    end
    drv(); set_cpu(0, 0, 0, 0, 0); set_ldr(0, 0, 0, 0, 0, 0);
    smp(); chk("alt last cpu_rvalid", cpu_rvalid, 1); chk("alt ldr_rdata", ldr_rdata, 32'hDEADBEEF);

    // Loader lock burst with the CPU waiting throughout.
    drv(); set_cpu(1, 0, 0, 32'h104, 0);
    for (int k = 0; k < 3; k++) begin
      set_ldr(1, 1, 0, 1, 32'h200 + 32'(4 * k), 32'hA0 + 32'(k));
      smp(); chk("lock ldr_gnt", ldr_gnt, 1); chk("lock cpu_gnt", cpu_gnt, 0);
      drv();
    end
    set_ldr(0, 0, 0, 0, 0, 0);
    smp(); chk("unlock cpu_gnt", cpu_gnt, 0);
    drv(); smp(); chk("after lock cpu_gnt", cpu_gnt, 1);
    drv(); set_cpu(0, 0, 0, 0, 0);

    // Loader byte write passes straight through.
    set_ldr(1, 1, 1, 0, 32'h203, 32'h5A);
    smp(); chk("byte ldr_gnt", ldr_gnt, 1); chk("byte mem_byteop", mem_byteop, 1);
    chk("byte mem_addr", mem_addr, 32'h203); chk("byte mem_wdata", mem_wdata, 32'h5A);
    drv(); set_ldr(0, 0, 0, 0, 0, 0);

    // Idle.
    repeat (10) begin
      smp();
      chk("idle gnt", {cpu_gnt, ldr_gnt}, 0);
      chk("idle rvalid", {cpu_rvalid, ldr_rvalid}, 0);
      chk("idle mem_we", mem_we, 0);
      drv();
    end

    // Reset in the middle of a read.
    set_cpu(1, 0, 0, 32'h100, 0);
    smp(); chk("rr cpu_gnt", cpu_gnt, 1);
    #1 rst_n = 0;
    #1 chk("rr gnt gated", cpu_gnt, 0); chk("rr mem_addr", mem_addr, 0);
    chk("rr cpu_rdata", cpu_rdata, 0);
    drv(); smp(); chk("rr no rvalid", cpu_rvalid, 0);
    drv(); set_cpu(0, 0, 0, 0, 0); rst_n = 1;
    smp(); chk("rr post rvalid", cpu_rvalid, 0);

    // Randomized traffic; requesters hold until granted, may give up.
    repeat (3000) begin
      drv();
      if (!cpu_req || c_took || $urandom_range(0, 9) == 0)
        set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 32'($urandom_range(0, 15)) << 2, $urandom);
      if (!ldr_req || l_took || (lock_left == 0 && $urandom_range(0, 9) == 0)) begin
        if (lock_left == 0 && $urandom_range(0, 7) == 0) lock_left = $urandom_range(2, 5);
        if (lock_left > 0) begin
          set_ldr(1, $urandom_range(0, 1) == 1, 0, lock_left > 1,
                  32'($urandom_range(0, 15)) << 2, $urandom);
          lock_left--;
        end else
          set_ldr($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 0, 32'($urandom_range(0, 15)) << 2, $urandom);
      end
    end
    drv(); set_cpu(0, 0, 0, 0, 0); set_ldr(0, 0, 0, 0, 0, 0);
    repeat (3) drv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
